// File: rtl/io_arb_pkg.sv
// Shared types and defaults for the two-master IO-bus arbiter.
// No logic here; timing and backpressure are defined by io_arbiter.
package io_arb_pkg;
    localparam int          CNT_W       = 10;
    localparam int          ADR_W       = 17;
    localparam int          TIMEOUT_DEF = 255;
    localparam logic [31:0] ERRDATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;
endpackage

// File: rtl/io_arbiter_if.sv
// Wishbone-style classic-cycle bus; master drives strobes, slave returns data/ack/err.
// Pure wiring, zero latency; the slave holds off a strobe by withholding ack.
interface io_arbiter_if;
    import io_arb_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat_w;
    logic [3:0]       sel;
    logic [31:0]      dat_r;
    logic             ack;
    logic             err;

    // The downstream IO controller never signals err, so the master side omits it.
    modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/io_arb_timer.sv
// Strobe watchdog: counts un-acked strobe cycles, flags the cycle that would reach TIMEOUT.
// expired is combinational in the TIMEOUT-th strobe cycle; clr (ack) in that cycle suppresses it.
module io_arb_timer
    import io_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      cnt <= '0;
        else if (clr)   cnt <= '0;
        else if (en)    cnt <= cnt + 1'b1;
    end

    assign expired = en && !clr && (cnt == LAST);
endmodule

// File: rtl/io_arbiter.sv
// Two-master round-robin arbiter onto one IO bus with locked cycles and strobe timeout.
// Grant one cycle after cyc is seen; data/ack pass through combinationally; waiters see nothing.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int          TIMEOUT = TIMEOUT_DEF,
    parameter logic [31:0] ERRDATA = ERRDATA_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    io_arbiter_if.slave  m0,
    io_arbiter_if.slave  m1,
    io_arbiter_if.master s,
    output logic [1:0]   grant_o
);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] OWN0 = ST_OWN0;
    localparam logic [1:0] OWN1 = ST_OWN1;
    localparam logic [1:0] ERR  = ST_ERR;

    logic [1:0] state, state_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic       own0, own1, err_st;
    logic       expired;

    assign own0   = (state == OWN0);
    assign own1   = (state == OWN1);
    assign err_st = (state == ERR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // last_gnt is written on leaving ownership, so in ERR it names the faulted master.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc) state_nxt = last_gnt ? OWN0 : OWN1;
                else if (m0.cyc)      state_nxt = OWN0;
                else if (m1.cyc)      state_nxt = OWN1;
            end
            OWN0: begin
                if (!m0.cyc || expired) begin
                    state_nxt    = m0.cyc ? ERR : IDLE;
                    last_gnt_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (!m1.cyc || expired) begin
                    state_nxt    = m1.cyc ? ERR : IDLE;
                    last_gnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.cyc   = own0 | own1;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = '0;
        s.dat_w = '0;
        s.sel   = '0;
        if (own0) begin
            s.stb   = m0.stb;
            s.we    = m0.we;
            s.adr   = m0.adr;
            s.dat_w = m0.dat_w;
            s.sel   = m0.sel;
        end else if (own1) begin
            s.stb   = m1.stb;
            s.we    = m1.we;
            s.adr   = m1.adr;
            s.dat_w = m1.dat_w;
            s.sel   = m1.sel;
        end
    end

    always_comb begin
        m0.ack   = own0 & s.ack & m0.stb;
        m1.ack   = own1 & s.ack & m1.stb;
        m0.err   = err_st & ~last_gnt;
        m1.err   = err_st &  last_gnt;
        m0.dat_r = '0;
        m1.dat_r = '0;
        if (own0)        m0.dat_r = s.dat_r;
        else if (own1)   m1.dat_r = s.dat_r;
        else if (err_st) begin
            if (last_gnt) m1.dat_r = ERRDATA;
            else          m0.dat_r = ERRDATA;
        end
    end

    assign grant_o = {own1, own0};

    io_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (s.ack | ~s.stb),
        .en      (s.stb),
        .expired (expired)
    );
endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: arbitration, locked cycles, timeout and reset.
module tb_io_arbiter;
    import io_arb_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] grant_o;
    int         tests = 0;
    int         fails = 0;

    io_arbiter_if m0_bus ();
    io_arbiter_if m1_bus ();
    io_arbiter_if s_bus ();

    io_arbiter #(.TIMEOUT(8), .ERRDATA(32'hDEADBEEF)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .grant_o (grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_m0(input logic cyc, input logic stb, input logic we,
                          input logic [16:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
        m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
    endtask

    task automatic set_m1(input logic cyc, input logic stb, input logic we,
                          input logic [16:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
        m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
    endtask

    task automatic set_slave(input logic ack, input logic [31:0] dat);
        s_bus.ack   = ack;
        s_bus.dat_r = dat;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_scyc"},  32'(s_bus.cyc),   32'h0);
        chk({tag, "_sstb"},  32'(s_bus.stb),   32'h0);
        chk({tag, "_swe"},   32'(s_bus.we),    32'h0);
        chk({tag, "_sadr"},  32'(s_bus.adr),   32'h0);
        chk({tag, "_sdat"},  s_bus.dat_w,      32'h0);
        chk({tag, "_ssel"},  32'(s_bus.sel),   32'h0);
        chk({tag, "_m0ack"}, 32'(m0_bus.ack),  32'h0);
        chk({tag, "_m0err"}, 32'(m0_bus.err),  32'h0);
        chk({tag, "_m0dat"}, m0_bus.dat_r,     32'h0);
        chk({tag, "_m1ack"}, 32'(m1_bus.ack),  32'h0);
        chk({tag, "_m1err"}, 32'(m1_bus.err),  32'h0);
        chk({tag, "_m1dat"}, m1_bus.dat_r,     32'h0);
        chk({tag, "_grant"}, 32'(grant_o),     32'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        set_m0(0, 0, 0, 17'h0, 32'h0, 4'h0);
        set_m1(0, 0, 0, 17'h0, 32'h0, 4'h0);
        set_slave(0, 32'h12345678);
        s_bus.err = 1'b0;
        repeat (2) tick;
        settle;
        chk_quiet("reset");
        rst_i = 1'b0;

        // Simultaneous request after reset: m0 first, then round-robin hands to m1.
        tick;
        set_m0(1, 1, 0, 17'h00010, 32'h0, 4'hF);
        set_m1(1, 1, 1, 17'h00020, 32'h11110000, 4'h3);
        settle;
        chk("tie_idle_grant", 32'(grant_o), 32'h0);
        chk("tie_idle_scyc", 32'(s_bus.cyc), 32'h0);
        tick;
        set_slave(1, 32'h00000055);
        settle;
        chk("tie_grant_m0", 32'(grant_o), 32'h1);
        chk("tie_sadr", 32'(s_bus.adr), 32'h00010);
        chk("tie_swe", 32'(s_bus.we), 32'h0);
        chk("tie_m0ack", 32'(m0_bus.ack), 32'h1);
        chk("tie_m0dat", m0_bus.dat_r, 32'h00000055);
        chk("tie_m1ack", 32'(m1_bus.ack), 32'h0);
        chk("tie_m1dat", m1_bus.dat_r, 32'h0);
        tick;
        set_m0(0, 0, 0, 17'h0, 32'h0, 4'h0);
        set_slave(0, 32'h0);
        settle;
        chk("rel0_grant", 32'(grant_o), 32'h1);
        chk("rel0_sstb", 32'(s_bus.stb), 32'h0);
        tick;
        set_m0(1, 1, 0, 17'h00030, 32'h0, 4'hF);
        settle;
        chk("rel0_idle_grant", 32'(grant_o), 32'h0);

        // m1 locked burst of four writes while m0 keeps requesting.
        for (int i = 0; i < 4; i++) begin
            tick;
            set_m1(1, 1, 1, 17'(32'h20 + i), 32'h11110000 + 32'(i), 4'h3);
            set_slave(1, 32'h0);
            settle;
            chk("burst_grant", 32'(grant_o), 32'h2);
            chk("burst_sadr", 32'(s_bus.adr), 32'h20 + 32'(i));
            chk("burst_sdat", s_bus.dat_w, 32'h11110000 + 32'(i));
            chk("burst_ssel", 32'(s_bus.sel), 32'h3);
            chk("burst_swe", 32'(s_bus.we), 32'h1);
            chk("burst_m1ack", 32'(m1_bus.ack), 32'h1);
            chk("burst_m0ack", 32'(m0_bus.ack), 32'h0);
            chk("burst_m0dat", m0_bus.dat_r, 32'h0);
        end
        tick;
        set_m1(0, 0, 0, 17'h0, 32'h0, 4'h0);
        set_slave(0, 32'h0);
        settle;
        chk("rel1_grant", 32'(grant_o), 32'h2);
        chk("rel1_m1ack", 32'(m1_bus.ack), 32'h0);
        tick;
        settle;
        chk("rel1_idle_grant", 32'(grant_o), 32'h0);
        tick;
        set_m0(0, 0, 0, 17'h0, 32'h0, 4'h0);
        settle;
        chk("after_burst_grant_m0", 32'(grant_o), 32'h1);
        chk("after_burst_scyc", 32'(s_bus.cyc), 32'h1);
        tick;
        settle;
        chk("m0_rel_idle", 32'(grant_o), 32'h0);

        // Single m0 read, slave acks in the third owned cycle.
        set_m0(1, 1, 0, 17'h01000, 32'h0, 4'hF);
        settle;
        chk("rd_idle_grant", 32'(grant_o), 32'h0);
        tick;
        settle;
        chk("rd_grant", 32'(grant_o), 32'h1);
        chk("rd_sstb", 32'(s_bus.stb), 32'h1);
        chk("rd_sadr", 32'(s_bus.adr), 32'h01000);
        chk("rd_ssel", 32'(s_bus.sel), 32'hF);
        chk("rd_c1_ack", 32'(m0_bus.ack), 32'h0);
        tick;
        settle;
        chk("rd_c2_ack", 32'(m0_bus.ack), 32'h0);
        tick;
        set_slave(1, 32'h0000ABCD);
        settle;
        chk("rd_ack", 32'(m0_bus.ack), 32'h1);
        chk("rd_dat", m0_bus.dat_r, 32'h0000ABCD);
        chk("rd_m1ack", 32'(m1_bus.ack), 32'h0);
        chk("rd_m1dat", m1_bus.dat_r, 32'h0);
        chk("rd_m1err", 32'(m1_bus.err), 32'h0);
        tick;
        set_m0(0, 0, 0, 17'h0, 32'h0, 4'h0);
        set_slave(0, 32'h0000ABCD);
        settle;
        chk("rd_ack_once", 32'(m0_bus.ack), 32'h0);
        tick;
        settle;
        chk("rd_idle_grant2", 32'(grant_o), 32'h0);
        chk("rd_idle_scyc", 32'(s_bus.cyc), 32'h0);

        // Slave never acks: eight strobe cycles, then one error cycle.
        set_m0(1, 1, 0, 17'h00100, 32'h0, 4'hF);
        set_slave(0, 32'h77777777);
        for (int i = 1; i <= 8; i++) begin
            tick;
            settle;
            chk("to_sstb", 32'(s_bus.stb), 32'h1);
            chk("to_m0err", 32'(m0_bus.err), 32'h0);
        end
        tick;
        settle;
        chk("to_err_sstb", 32'(s_bus.stb), 32'h0);
        chk("to_err_scyc", 32'(s_bus.cyc), 32'h0);
        chk("to_err_m0err", 32'(m0_bus.err), 32'h1);
        chk("to_err_m0dat", m0_bus.dat_r, 32'hDEADBEEF);
        chk("to_err_m0ack", 32'(m0_bus.ack), 32'h0);
        chk("to_err_grant", 32'(grant_o), 32'h0);
        chk("to_err_m1err", 32'(m1_bus.err), 32'h0);
        set_m0(0, 0, 0, 17'h0, 32'h0, 4'h0);
        tick;
        settle;
        chk("to_idle_m0err", 32'(m0_bus.err), 32'h0);
        chk("to_idle_m0dat", m0_bus.dat_r, 32'h0);
        chk("to_idle_grant", 32'(grant_o), 32'h0);

        // Ack lands in the eighth strobe cycle: ack wins over timeout.
        set_m0(1, 1, 0, 17'h00104, 32'h0, 4'hF);
        set_slave(0, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            tick;
            settle;
            chk("race_sstb", 32'(s_bus.stb), 32'h1);
            chk("race_m0ack", 32'(m0_bus.ack), 32'h0);
        end
        tick;
        set_slave(1, 32'hCAFE0008);
        settle;
        chk("race_ack", 32'(m0_bus.ack), 32'h1);
        chk("race_err", 32'(m0_bus.err), 32'h0);
        chk("race_dat", m0_bus.dat_r, 32'hCAFE0008);
        tick;
        set_m0(0, 0, 0, 17'h0, 32'h0, 4'h0);
        set_slave(0, 32'h0);
        settle;
        chk("race_after_err", 32'(m0_bus.err), 32'h0);
        chk("race_after_grant", 32'(grant_o), 32'h1);
        chk("race_after_scyc", 32'(s_bus.cyc), 32'h1);
        tick;
        settle;
        chk("race_idle_grant", 32'(grant_o), 32'h0);

        // Reset in the middle of an m1 strobe; afterwards m0 must win the tie.
        set_m1(1, 1, 1, 17'h00200, 32'hA5A5A5A5, 4'hF);
        tick;
        settle;
        chk("rstm_grant_m1", 32'(grant_o), 32'h2);
        chk("rstm_sstb", 32'(s_bus.stb), 32'h1);
        tick;
        rst_i = 1'b1;
        set_slave(1, 32'h99999999);
        settle;
        chk_quiet("rst_mid");
        tick;
        settle;
        chk_quiet("rst_hold");
        rst_i = 1'b0;
        set_slave(0, 32'h0);
        set_m0(1, 1, 0, 17'h00300, 32'h0, 4'hF);
        settle;
        chk("post_rst_idle_grant", 32'(grant_o), 32'h0);
        tick;
        settle;
        chk("post_rst_tie_m0", 32'(grant_o), 32'h1);
        chk("post_rst_sadr", 32'(s_bus.adr), 32'h00300);

        set_m0(0, 0, 0, 17'h0, 32'h0, 4'h0);
        set_m1(0, 0, 0, 17'h0, 32'h0, 4'h0);
        repeat (2) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, slave cycles allowed per strobe before bus error (range 1..1023).
REQ-002 Parameter ERRDATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-003 clk_i  in  1  system clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  master N (N=0,1) Wishbone cycle/strobe/write.
REQ-006 mN_adr_i  in  17  master N address.
REQ-007 mN_dat_i  in  32  master N write data; mN_sel_i  in  4  byte selects.
REQ-008 mN_dat_o  out  32  master N read data; mN_ack_o, mN_err_o  out  1 each  completion/error.
REQ-009 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared IO-bus strobes to the IO controller.
REQ-010 s_adr_o  out  17; s_dat_o  out  32; s_sel_o  out  4  forwarded from granted master.
REQ-011 s_dat_i  in  32; s_ack_i  in  1  IO controller response.
REQ-012 grant_o  out  2  one-hot current owner (bit N = master N), for debug/LEDs.

Function
REQ-013 States: IDLE, OWN0, OWN1, ERR; encoding registered, 2 bits.
REQ-014 IDLE: arbitration sampled on mN_cyc_i; single requester wins; both requesting -> winner is master not granted last (round-robin), master 0 if none granted since reset.
REQ-015 Grant takes effect cycle after request seen; s_cyc_o asserts same edge state enters OWNn.
REQ-016 OWNn: s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o combinationally follow master n; other master sees ack/err low, dat_o 0.
REQ-017 Ownership held while mn_cyc_i high (locked multi-transfer cycles); mn_cyc_i low -> IDLE next edge, last-granted updated to n.
REQ-018 mn_ack_o = s_ack_i & mn_stb_i while OWNn; mn_dat_o = s_dat_i, passed through zero-latency.
REQ-019 Timeout counter (10 bits) clears on s_ack_i or s_stb_o low, increments each cycle s_stb_o high without ack.
REQ-020 Counter reaching TIMEOUT -> ERR: s_stb_o and s_cyc_o forced low, mn_err_o high exactly one cycle, mn_dat_o = ERRDATA that cycle.
REQ-021 ERR -> IDLE next edge unconditionally; owner recorded as last-granted; master must re-request.
REQ-022 s_ack_i arriving in same cycle counter hits TIMEOUT: ack wins, no error.
REQ-023 s_ack_i while IDLE or ERR ignored, not forwarded.
REQ-024 Master dropping cyc mid-strobe: release as REQ-017; s_cyc_o low next edge regardless of pending ack.
REQ-025 Never both grant bits set; grant_o = 2'b00 in IDLE and ERR.

Reset
REQ-026 rst_i high: state IDLE, last-granted = master 1 (so master 0 wins first tie), counter 0.
REQ-027 During and after reset until first grant: all s_* outputs 0, all mN_ack_o/mN_err_o 0, mN_dat_o 0, grant_o 0.
REQ-028 Reset mid-transfer abandons transaction without ack or err.

Structure
REQ-029 Package io_arb_pkg holds state enum, TIMEOUT/ERRDATA defaults, counter width constant.
REQ-030 Sub-module io_arb_timer: timeout counter with clear, enable, expired outputs; arbiter FSM and muxes in io_arbiter.
REQ-031 No clock gating; single clock domain; no latches.

Verification
REQ-032 Only m0 reads adr 0x01000, slave acks after 3 cycles with 0x0000ABCD -> m0_ack_o one cycle, m0_dat_o 0x0000ABCD, m1 silent.
REQ-033 m0 and m1 request same cycle after reset -> m0 granted; after m0 releases with m1 still requesting -> m1 granted next IDLE.
REQ-034 m1 holds cyc for 4 back-to-back writes, m0 requests throughout -> all 4 complete on m1 before grant_o = 2'b01.
REQ-035 TIMEOUT=8, slave never acks -> s_stb_o drops after 8 strobe cycles, m0_err_o one cycle, m0_dat_o 0xDEADBEEF, state IDLE next.
REQ-036 s_ack_i coincident with 8th timeout cycle -> m0_ack_o, no err.
REQ-037 rst_i pulsed mid-strobe of m1 -> all outputs 0 during reset, no ack/err, m0 wins first subsequent tie.
